// File: rtl/interrupt_controller_if.sv
// Shared 32-bit port bus between the processor side and the interrupt controller.
// data is bidirectional: the controller drives it only during a read strobe.
interface interrupt_controller_if;
    wire  [31:0] data;
    logic        read;
    logic        write;

    modport master (inout data, output read, output write);
    modport slave  (inout data, input read, input write);
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered interrupt aggregator: sticky pending/missed bits, mask,
// lowest-index priority encoder and a registered request, managed over a port bus.
module interrupt_controller #(
    parameter int unsigned NUM_SOURCES = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    interrupt_controller_if.slave  bus,
    input  logic [NUM_SOURCES-1:0] irqIn,
    output logic                   interupt
);
    localparam int unsigned N       = NUM_SOURCES;
    localparam int unsigned BUS_W   = 32;
    localparam logic [3:0]  OP_MASK = 4'h1;
    localparam logic [3:0]  OP_ACK  = 4'h2;
    localparam logic [3:0]  OP_CLR  = 4'h3;
    localparam logic [3:0]  OP_VIEW = 4'h4;

    logic [N-1:0]       irqPrev;
    logic [N-1:0]       pending;
    logic [N-1:0]       missed;
    logic [N-1:0]       mask;
    logic [1:0]         view;
    logic [N-1:0]       edges;
    logic [N-1:0]       ackVec;
    logic [N-1:0]       pendingNext;
    logic [N-1:0]       missedNext;
    logic [BUS_W-1:0]   busIn;
    logic [3:0]         opcode;
    logic               valid;
    logic [3:0]         vector;
    logic [BUS_W-1:0]   readData;
    logic               unusedBits;

    assign busIn      = bus.data;
    assign opcode     = busIn[31:28];
    assign unusedBits = ^busIn[27:16];
    assign edges      = irqIn & ~irqPrev;

    // Per-source clear request from an ack (single index) or clear-all command.
    always_comb begin
        ackVec = '0;
        if (bus.write) begin
            if (opcode == OP_CLR) begin
                ackVec = '1;
            end else if (opcode == OP_ACK) begin
                for (int i = 0; i < int'(N); i++) begin
                    if (busIn[3:0] == 4'(i)) ackVec[i] = 1'b1;
                end
            end
        end
    end

    // A new edge beats a same-cycle clear; missed is then left untouched.
    assign pendingNext = (pending & ~ackVec) | edges;
    assign missedNext  = (missed & ~(ackVec & ~edges)) | (edges & pending & ~ackVec);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            irqPrev  <= '0;
            pending  <= '0;
            missed   <= '0;
            mask     <= '0;
            view     <= 2'd0;
            interupt <= 1'b0;
        end else begin
            irqPrev  <= irqIn;
            pending  <= pendingNext;
            missed   <= missedNext;
            interupt <= |(pending & mask);
            if (bus.write && opcode == OP_MASK) mask <= busIn[N-1:0];
            if (bus.write && opcode == OP_VIEW) view <= busIn[1:0];
        end
    end

    // Lowest enabled index wins: scan downward so the last hit is the smallest.
    always_comb begin
        valid  = 1'b0;
        vector = 4'd0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (pending[i] && mask[i]) begin
                valid  = 1'b1;
                vector = 4'(i);
            end
        end
    end

    always_comb begin
        readData = '0;
        case (view)
            2'd0:    readData = {valid, 27'd0, vector};
            2'd1:    readData = BUS_W'(pending);
            2'd2:    readData = BUS_W'(mask);
            default: readData = BUS_W'(missed);
        endcase
    end

    assign bus.data = bus.read ? readData : {BUS_W{1'bz}};
endmodule
